// File: rtl/ram_fifo_pkg.sv
// Shared defaults and the per-cycle RAM grant type for the RAM-backed FIFO controller.
package ram_fifo_pkg;

  localparam int DEF_DW    = 4;
  localparam int DEF_AW    = 3;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_WRITE,
    OP_READ
  } op_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: advances on inc, returns to zero after DEPTH-1.
module fifo_ptr #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inc,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int PW = $clog2(DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      if (ptr == PW'(DEPTH - 1)) ptr <= '0;
      else                       ptr <= ptr + PW'(1);
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving a single-port RAM plus a one-entry output register.
// Define RAM_FIFO_BYPASS_EN to let pushes into an empty FIFO skip the RAM.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [2:0]    level,
  output logic          ram_wr,
  output logic          ram_rd,
  output logic [AW-1:0] ram_add,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  op_t           op;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] ram_cnt;
  logic [CW-1:0] ram_cnt_nxt;
  logic          full;
  logic          can_load;
  logic          bypass;
  logic          out_valid_nxt;
  logic [DW-1:0] out_data_nxt;

  assign full     = (ram_cnt == CW'(DEPTH));
  assign can_load = !out_valid || out_ready;

  // Refilling the output register wins over accepting new data.
  always_comb begin
    op     = OP_NONE;
    bypass = 1'b0;
    if (ram_cnt != '0 && can_load) begin
      op = OP_READ;
    end else if (in_valid && !full) begin
`ifdef RAM_FIFO_BYPASS_EN
      if (ram_cnt == '0 && can_load) bypass = 1'b1;
      else                           op     = OP_WRITE;
`else
      op = OP_WRITE;
`endif
    end
  end

  always_comb begin
    ram_wr  = 1'b0;
    ram_rd  = 1'b0;
    ram_add = '0;
    unique case (op)
      OP_READ: begin
        ram_rd  = 1'b1;
        ram_add = AW'(rptr);
      end
      OP_WRITE: begin
        ram_wr  = 1'b1;
        ram_add = AW'(wptr);
      end
      default: ;
    endcase
  end

  assign in_ready = rst_n && !full && (op != OP_READ);
  assign ram_din  = in_data;

  always_comb begin
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    ram_cnt_nxt   = ram_cnt;
    if (op == OP_READ) begin
      out_valid_nxt = 1'b1;
      out_data_nxt  = ram_dout;
      ram_cnt_nxt   = ram_cnt - CW'(1);
    end else if (bypass) begin
      out_valid_nxt = 1'b1;
      out_data_nxt  = in_data;
    end else if (out_valid && out_ready) begin
      out_valid_nxt = 1'b0;
    end
    if (op == OP_WRITE) ram_cnt_nxt = ram_cnt + CW'(1);
  end

  // level is registered from next-state values so it tracks ram_cnt + out_valid exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      level     <= '0;
    end else begin
      ram_cnt   <= ram_cnt_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      level     <= 3'(ram_cnt_nxt) + 3'(out_valid_nxt);
    end
  end

  fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (op == OP_WRITE),
    .ptr   (wptr)
  );

  fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (op == OP_READ),
    .ptr   (rptr)
  );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: queue-based FIFO model plus a behavioural RAM.
module tb_ram_fifo_ctrl;

  localparam int DW    = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    level;
  logic          ram_wr;
  logic          ram_rd;
  logic [AW-1:0] ram_add;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  logic [DW-1:0] mem [2**AW];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [DW-1:0] m_ram [$];
  logic [DW-1:0] popped [$];
  bit            m_ov;
  logic [DW-1:0] m_od;
  int unsigned   m_rd_n;
  int unsigned   m_wr_n;

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_wr) mem[ram_add] <= ram_din;
  assign ram_dout = ram_rd ? mem[ram_add] : 'z;

  ram_fifo_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .ram_wr    (ram_wr),
    .ram_rd    (ram_rd),
    .ram_add   (ram_add),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ram.delete();
    m_ov   = 1'b0;
    m_od   = '0;
    m_rd_n = 0;
    m_wr_n = 0;
  endtask

  // One clock: drive at negedge, check grant outputs, then check registered state after posedge.
  task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy, output bit acc);
    bit rd, wr, byp, exp_ir;
    int unsigned cnt;
    int exp_add;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    cnt = m_ram.size();
    rd  = (cnt > 0) && (!m_ov || ordy);
    wr  = !rd && iv && (cnt < DEPTH);
    byp = 1'b0;
`ifdef RAM_FIFO_BYPASS_EN
    if (wr && cnt == 0 && (!m_ov || ordy)) begin
      byp = 1'b1;
      wr  = 1'b0;
    end
`endif
    exp_ir  = (cnt != DEPTH) && !rd;
    exp_add = rd ? int'(m_rd_n % DEPTH) : (wr ? int'(m_wr_n % DEPTH) : 0);
    #1;
    check("in_ready", 32'(in_ready), 32'(exp_ir));
    check("ram_wr",   32'(ram_wr),   32'(wr));
    check("ram_rd",   32'(ram_rd),   32'(rd));
    check("ram_add",  32'(ram_add),  32'(exp_add));
    check("no_dual_op", 32'(ram_wr & ram_rd), 32'd0);
    acc = wr || byp;
    @(posedge clk);
    if (m_ov && ordy) popped.push_back(m_od);
    if (rd) begin
      m_od = m_ram.pop_front();
      m_ov = 1'b1;
      m_rd_n++;
    end else if (byp) begin
      m_od = id;
      m_ov = 1'b1;
    end else if (m_ov && ordy) begin
      m_ov = 1'b0;
    end
    if (wr) begin
      m_ram.push_back(id);
      m_wr_n++;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_data",  32'(out_data),  32'(m_od));
    check("level",     32'(level),     32'(m_ram.size() + int'(m_ov)));
  endtask

  task automatic push_word(input logic [DW-1:0] d, input bit rand_ready);
    bit acc;
    int unsigned n;
    logic r;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
      step(1'b1, d, r, acc);
      n++;
    end
    if (!acc) check("push_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    bit acc;
    int unsigned n;
    n = 0;
    while ((m_ram.size() != 0 || m_ov) && n < 20) begin
      step(1'b0, '0, 1'b1, acc);
      n++;
    end
    if (m_ram.size() != 0 || m_ov) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit acc;
    logic [DW-1:0] fill_vals [5];
    fill_vals = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level",     32'(level),     32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-stream
    for (int i = 0; i < 3; i++) push_word(4'(i + 3), 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_level",     32'(level),     32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    popped.delete();
    push_word(4'h1, 1'b0);
    drain();
    check("midrst_first_pop", 32'(popped.size() > 0 ? popped[0] : 4'hF), 32'h1);

    // Latency into an empty FIFO
    step(1'b1, 4'h7, 1'b0, acc);
`ifdef RAM_FIFO_BYPASS_EN
    check("lat_e0_valid", 32'(out_valid), 32'd1);
`else
    check("lat_e0_valid", 32'(out_valid), 32'd0);
`endif
    step(1'b0, '0, 1'b0, acc);
    check("lat_e1_valid", 32'(out_valid), 32'd1);
    check("lat_e1_data",  32'(out_data),  32'h7);
    drain();

    // Fill to capacity
    popped.delete();
    for (int i = 0; i < 5; i++) push_word(fill_vals[i], 1'b0);
    step(1'b1, 4'hF, 1'b0, acc);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_level",    32'(level),    32'd5);
    check("full_stall",    32'(acc),      32'd0);
    drain();
    check("fill_pop_count", 32'(popped.size()), 32'd5);
    for (int i = 0; i < 5 && i < popped.size(); i++)
      check("fill_order", 32'(popped[i]), 32'(fill_vals[i]));

    // Wrap-around with random consumer
    popped.delete();
    for (int v = 0; v < 10; v++) push_word(4'(v), 1'b1);
    drain();
    check("wrap_pop_count", 32'(popped.size()), 32'd10);
    for (int i = 0; i < 10 && i < popped.size(); i++)
      check("wrap_order", 32'(popped[i]), 32'(i));

    // Arbitration under continuous push and pop
    popped.delete();
    push_word(4'h2, 1'b0);
    push_word(4'h3, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 4'(i + 4), 1'b1, acc);
    drain();

    // Empty pop
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1, acc);
      check("empty_out_valid", 32'(out_valid), 32'd0);
      check("empty_level",     32'(level),     32'd0);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 2) != 0), acc);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
